// File: rtl/fifo_pkg.sv
// Shared widths, error encoding and default thresholds for the single-clock FIFO.
package fifo_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_DEPTH  = 16;
  localparam int DEFAULT_AEMPTY = 2;

  typedef enum logic [1:0] {
    FIFO_ERR_NONE = 2'b00,
    FIFO_ERR_WR   = 2'b01,
    FIFO_ERR_RD   = 2'b10,
    FIFO_ERR_BOTH = 2'b11
  } fifo_err_e;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy has to reach DEPTH itself, hence one bit more than an address.
  function automatic int cnt_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus of sync_fifo_param: push/pop handshake, read data and status.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);
  localparam int CW = cnt_width(DEPTH);

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic             rd_en;
  logic [WIDTH-1:0] rdata;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             wr_err;
  logic             rd_err;

  modport master (
    output flush, wr_en, wdata, rd_en,
    input  rdata, rd_valid, full, empty, almost_full, almost_empty, count, wr_err, rd_err
  );

  modport slave (
    input  flush, wr_en, wdata, rd_en,
    output rdata, rd_valid, full, empty, almost_full, almost_empty, count, wr_err, rd_err
  );

endinterface

// File: rtl/fifo_dp_ram.sv
// Storage for sync_fifo_param: one write port, one read port. Registered read by default,
// combinational read when SYNC_FIFO_FWFT_EN is defined.
module fifo_dp_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port; the array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic unused_s;
  assign unused_s = rst ^ re_i;
  assign rdata_o  = mem_q[raddr_i];
`else
  logic [WIDTH-1:0] rdata_q;

  // Read register: old contents win when the same slot is written on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= {WIDTH{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, almost flags, flush and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int PTR_WIDTH     = ptr_width(DEPTH),
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = DEFAULT_AEMPTY
) (
  input  logic              clk,
  input  logic              rst,
  sync_fifo_param_if.slave  bus
);

  localparam int CW = PTR_WIDTH + 1;
  localparam logic [CW-1:0] AF_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_C  = CW'(AEMPTY_THRESH);
  localparam logic [CW-1:0] ONE_C = {{PTR_WIDTH{1'b0}}, 1'b1};

  logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          afull_q, afull_d, aempty_q, aempty_d;
  logic          rd_valid_q, rd_valid_d;
  fifo_err_e     err_q, err_d;
  logic          wr_acc_s, rd_acc_s;

  // Accept rules: a pop frees the slot a same-cycle push into a full FIFO needs.
  always_comb begin
    rd_acc_s = 1'b0;
    wr_acc_s = 1'b0;
    if (rst || bus.flush) begin
      rd_acc_s = 1'b0;
      wr_acc_s = 1'b0;
    end else begin
      rd_acc_s = bus.rd_en && !empty_q;
      wr_acc_s = bus.wr_en && (!full_q || rd_acc_s);
    end
  end

  // Next-state pointers, count and flags, so flags land on the same edge as the count.
  always_comb begin
    wr_ptr_d   = wr_acc_s ? (wr_ptr_q + ONE_C) : wr_ptr_q;
    rd_ptr_d   = rd_acc_s ? (rd_ptr_q + ONE_C) : rd_ptr_q;
    count_d    = count_q;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    full_d     = (wr_ptr_d[PTR_WIDTH-1:0] == rd_ptr_d[PTR_WIDTH-1:0]) &&
                 (wr_ptr_d[PTR_WIDTH] != rd_ptr_d[PTR_WIDTH]);
    empty_d    = (wr_ptr_d == rd_ptr_d);
    afull_d    = (count_d >= AF_C);
    aempty_d   = (count_d <= AE_C);
    rd_valid_d = rd_acc_s;
    err_d      = fifo_err_e'({bus.rd_en && !rd_acc_s && !bus.flush,
                              bus.wr_en && !wr_acc_s && !bus.flush});
  end

  // State register; flush clears like reset but leaves the read data register alone.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr_q   <= {CW{1'b0}};
      rd_ptr_q   <= {CW{1'b0}};
      count_q    <= {CW{1'b0}};
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      rd_valid_q <= 1'b0;
      err_q      <= FIFO_ERR_NONE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  fifo_dp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_acc_s),
    .waddr_i (wr_ptr_q[PTR_WIDTH-1:0]),
    .wdata_i (bus.wdata),
    .re_i    (rd_acc_s),
    .raddr_i (rd_ptr_q[PTR_WIDTH-1:0]),
    .rdata_o (bus.rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  logic unused_rd_valid_s;
  assign unused_rd_valid_s = rd_valid_q;
  assign bus.rd_valid      = !empty_q;
`else
  assign bus.rd_valid      = rd_valid_q;
`endif

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.wr_err       = err_q[0];
  assign bus.rd_err       = err_q[1];

endmodule
